// File: rtl/xor_mux_pkg.sv
// Shared definitions for the mux-built XOR stream accumulator: mode codes,
// FSM state constants and the beat-counter width helper.
package xor_mux_pkg;

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACC  = 2'd1;
  localparam state_t HOLD = 2'd2;

  // Counter must represent MAX_BEATS itself, hence the +1.
  function automatic int calc_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/xor_mux_stream_acc_lane.sv
// WIDTH-bit array of 2:1 mux XOR cells; inv turns every cell into XNOR by
// swapping the polarity of the mux data inputs.
module xor_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;

  assign d0 = inv ? ~b : b;
  assign d1 = inv ? b : ~b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign y[i] = a[i] ? d1[i] : d0[i];
  end

endmodule

// File: rtl/xor_mux_stream_acc.sv
// Registered XOR / XNOR / frame-accumulated XOR over a valid/ready stream.
// Define XOR_PARITY_OUT_EN to add the parity and par_err outputs.
module xor_mux_stream_acc
  import xor_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = calc_cnt_w(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] beats
`ifdef XOR_PARITY_OUT_EN
  ,
  output logic             parity,
  output logic             par_err
`endif
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] fold_base;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             first_beat;
  logic             beat_inv;
  logic             closes;

  assign in_ready = (state == HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid && in_ready;

  // HOLD behaves like IDLE for an incoming beat: it opens a new frame.
  assign first_beat = (state != ACC);
  assign beat_inv   = first_beat && (mode == MODE_XNOR);
  assign fold_base  = first_beat ? '0 : acc;
  assign cnt_inc    = first_beat ? CNT_W'(1) : cnt + CNT_W'(1);
  assign closes     = first_beat ? ((mode != MODE_ACC) || in_last)
                                 : (in_last || (cnt_inc == CNT_W'(MAX_BEATS)));

  xor_mux_lane #(.WIDTH(WIDTH)) u_beat_lane (
    .a   (A),
    .b   (B),
    .inv (beat_inv),
    .y   (beat_res)
  );

  xor_mux_lane #(.WIDTH(WIDTH)) u_fold_lane (
    .a   (fold_base),
    .b   (beat_res),
    .inv (1'b0),
    .y   (fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      beats     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if (closes) begin
        out       <= fold;
        beats     <= cnt_inc;
        out_valid <= 1'b1;
        state     <= HOLD;
      end else begin
        acc       <= fold;
        cnt       <= cnt_inc;
        out_valid <= 1'b0;
        state     <= ACC;
      end
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

`ifdef XOR_PARITY_OUT_EN
  logic acc_frame;
  logic err_q;

  assign acc_frame = !first_beat || (mode == MODE_ACC);
  assign par_err   = out_valid && err_q;

  // The closing beat's B MSB carries the producer's expected frame parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept && closes) begin
      parity <= ^fold;
      err_q  <= acc_frame && ((^fold) != B[WIDTH-1]);
    end else if (state == HOLD && out_ready) begin
      err_q  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_xor_mux_stream_acc.sv
// Self-checking bench for xor_mux_stream_acc: frame-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xor_mux_stream_acc;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             in_last = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] beats;
`ifdef XOR_PARITY_OUT_EN
  logic             parity;
  logic             par_err;
`endif

  always #5 clk = ~clk;

  xor_mux_stream_acc #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .beats     (beats)
`ifdef XOR_PARITY_OUT_EN
    ,
    .parity    (parity),
    .par_err   (par_err)
`endif
  );

  int n_tot  = 0;
  int n_pass = 0;

  // Reference model: one pending result and one open accumulate frame.
  bit         pending = 0;
  logic [7:0] p_out   = '0;
  int         p_beats = 0;
  bit         f_open  = 0;
  logic [7:0] f_acc   = '0;
  int         f_n     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    pending = 0;
    f_open  = 0;
    f_acc   = '0;
    f_n     = 0;
  endtask

  task automatic model_close();
    pending = 1;
    p_out   = f_acc;
    p_beats = f_n;
    f_open  = 0;
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(pending));
    chk("in_ready", 32'(in_ready), 32'(!pending || out_ready));
    if (pending) begin
      chk("out", 32'(out), 32'(p_out));
      chk("beats", 32'(beats), 32'(p_beats));
`ifdef XOR_PARITY_OUT_EN
      chk("parity", 32'(parity), 32'(^p_out));
`endif
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic last, input logic [1:0] md, input logic ordy);
    bit took;
    in_valid  = v;
    A         = a;
    B         = b;
    in_last   = last;
    mode      = md;
    out_ready = ordy;
    #1;
    compare();
    took = v && (!pending || ordy);
    if (pending && ordy) pending = 0;
    if (took) begin
      if (!f_open) begin
        if (md == 2'b10) begin
          f_open = 1;
          f_acc  = a ^ b;
          f_n    = 1;
          if (last) model_close();
        end else begin
          pending = 1;
          p_out   = (md == 2'b01) ? ~(a ^ b) : (a ^ b);
          p_beats = 1;
        end
      end else begin
        f_acc = f_acc ^ a ^ b;
        f_n++;
        if (last || f_n == MAX_BEATS) model_close();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_beats", 32'(beats), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Plain XOR beat, one cycle latency.
    step(1, 8'hA5, 8'h0F, 0, 2'b00, 1);
    chk("xor_valid", 32'(out_valid), 32'd1);
    chk("xor_out", 32'(out), 32'hAA);
    chk("xor_beats", 32'(beats), 32'd1);
    step(0, 8'h00, 8'h00, 0, 2'b00, 1);
    chk("xor_drained", 32'(out_valid), 32'd0);

    // XNOR held under backpressure, next beat taken on the draining edge.
    step(1, 8'hFF, 8'h0F, 0, 2'b01, 0);
    repeat (4) begin
      step(1, 8'h12, 8'h34, 0, 2'b00, 0);
      chk("xnor_hold_out", 32'(out), 32'h0F);
      chk("xnor_hold_ready", 32'(in_ready), 32'd0);
    end
    step(1, 8'h12, 8'h34, 0, 2'b00, 1);
    chk("drain_accept_valid", 32'(out_valid), 32'd1);
    chk("drain_accept_out", 32'(out), 32'h26);
    step(0, 8'h00, 8'h00, 0, 2'b00, 1);

    // Four-beat frame; the mid-frame mode change must be ignored.
    step(1, 8'h01, 8'h00, 0, 2'b10, 1);
    step(1, 8'h02, 8'h00, 0, 2'b00, 1);
    step(1, 8'h04, 8'h00, 0, 2'b01, 1);
    step(1, 8'h08, 8'h00, 1, 2'b10, 1);
    chk("acc4_out", 32'(out), 32'h0F);
    chk("acc4_beats", 32'(beats), 32'd4);
    step(0, 8'h00, 8'h00, 0, 2'b00, 1);

    // Force-close at MAX_BEATS with no in_last.
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (i == MAX_BEATS - 1) chk("force_open_valid", 32'(out_valid), 32'd0);
      step(1, 8'h01, 8'h00, 0, 2'b10, 1);
    end
    chk("force_valid", 32'(out_valid), 32'd1);
    chk("force_out", 32'(out), 32'h00);
    chk("force_beats", 32'(beats), 32'd16);
    step(0, 8'h00, 8'h00, 0, 2'b00, 1);
    chk("force_idle_valid", 32'(out_valid), 32'd0);
    chk("force_idle_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of an open frame.
    step(1, 8'h5A, 8'h00, 0, 2'b00, 1);
    step(1, 8'h11, 8'h00, 0, 2'b10, 1);
    step(1, 8'h22, 8'h00, 0, 2'b10, 1);
    step(1, 8'h44, 8'h00, 0, 2'b10, 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_beats", 32'(beats), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat frame, then a per-beat XOR with no bubble.
    step(1, 8'h3C, 8'hC3, 1, 2'b10, 1);
    chk("single_out", 32'(out), 32'hFF);
    chk("single_beats", 32'(beats), 32'd1);
    step(1, 8'hA5, 8'h0F, 0, 2'b00, 1);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_out", 32'(out), 32'hAA);
    step(0, 8'h00, 8'h00, 0, 2'b00, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0, 2'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
